// File: rtl/word_mem_streamer_pkg.sv
// word_mem_streamer_pkg: default geometry, dump FSM encoding and word-geometry helpers
package word_mem_streamer_pkg;
  localparam int DEF_MEM_DEPTH = 2048;
  localparam int DEF_MEM_WIDTH = 8;
  localparam int DEF_WORD_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;
  function automatic int bpw(input int word_width, input int mem_width);
    return word_width / mem_width;
  endfunction
  function automatic int wdepth(input int mem_depth, input int word_width, input int mem_width);
    return mem_depth / bpw(word_width, mem_width);
  endfunction
endpackage

// File: rtl/word_mem_streamer_byte_mem_bank.sv
// byte_mem_bank: byte array with one word port, synchronous write and big-endian byte assembly
module byte_mem_bank
  import word_mem_streamer_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int AW = $clog2(wdepth(DEF_MEM_DEPTH, DEF_WORD_WIDTH, DEF_MEM_WIDTH))
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);
  localparam int BPW = bpw(WORD_WIDTH, MEM_WIDTH);
  localparam int MAW = $clog2(MEM_DEPTH);
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MAW-1:0] base;
  assign base = MAW'(addr * BPW);
  // lowest byte address carries the most significant byte
  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < BPW; i++)
        mem[base + MAW'(i)] <= wdata[WORD_WIDTH-1-i*MEM_WIDTH -: MEM_WIDTH];
  always_comb begin
    rdata = '0;
    for (int i = 0; i < BPW; i++)
      rdata[WORD_WIDTH-1-i*MEM_WIDTH -: MEM_WIDTH] = mem[base + MAW'(i)];
  end
endmodule

// File: rtl/word_mem_streamer.sv
// word_mem_streamer: byte memory with a word host port and a valid/ready dump engine
module word_mem_streamer
  import word_mem_streamer_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int AW = $clog2(wdepth(MEM_DEPTH, WORD_WIDTH, MEM_WIDTH))
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  dump_start,
  input  logic [AW-1:0]         dump_base,
  input  logic [AW:0]           dump_count,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [WORD_WIDTH-1:0] dump_data,
  output logic [AW-1:0]         dump_addr,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  host_err
);
  localparam int WDEPTH = wdepth(MEM_DEPTH, WORD_WIDTH, MEM_WIDTH);
  state_t state, nxt;
  logic [AW-1:0] acnt, acnt_inc, bank_addr;
  logic [AW:0] rem;
  logic [WORD_WIDTH-1:0] bank_rdata;
  logic start, accept, done_n;
  assign dump_busy = state != IDLE;
  assign dump_valid = state == SEND;
  assign start = state == IDLE && dump_start;
  assign accept = dump_valid && dump_ready;
  assign acnt_inc = acnt == AW'(WDEPTH - 1) ? '0 : acnt + 1'b1;
  // the engine owns the single bank port for the whole dump
  assign bank_addr = dump_busy ? acnt : addr;
  byte_mem_bank #(
    .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH), .WORD_WIDTH(WORD_WIDTH), .AW(AW)
  ) u_bank (
    .clock(clock),
    .we(en && !dump_busy && wr_en),
    .addr(bank_addr),
    .wdata(wr_data),
    .rdata(bank_rdata)
  );
  always_comb begin
    nxt = state;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        nxt = start && dump_count != '0 ? FETCH : IDLE;
        done_n = start && dump_count == '0;
      end
      FETCH: nxt = SEND;
      SEND: begin
        nxt = accept ? (rem == (AW+1)'(1) ? IDLE : FETCH) : SEND;
        done_n = accept && rem == (AW+1)'(1);
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (rst) begin
      state <= IDLE;
      acnt <= '0;
      rem <= '0;
      rd_data <= '0;
      dump_data <= '0;
      dump_addr <= '0;
      dump_done <= 1'b0;
      host_err <= 1'b0;
    end else if (en) begin
      state <= nxt;
      dump_done <= done_n;
      if (start) begin
        acnt <= dump_base;
        rem <= dump_count;
      end
      if (state == FETCH) begin
        dump_data <= bank_rdata;
        dump_addr <= acnt;
      end
      if (accept) begin
        acnt <= acnt_inc;
        rem <= rem - 1'b1;
      end
      if (!dump_busy && rd_en) rd_data <= wr_en ? wr_data : bank_rdata;
      if (dump_busy && (wr_en || rd_en)) host_err <= 1'b1;
    end
endmodule

// File: tb/tb_word_mem_streamer.sv
// tb_word_mem_streamer: directed checks of host port, dump timing, wrap, backpressure, collision and reset
module tb_word_mem_streamer;
  logic clock = 1'b0;
  logic rst, en, wr_en, rd_en, dump_start, dump_ready;
  logic [9:0] addr, dump_base;
  logic [10:0] dump_count;
  logic [15:0] wr_data, rd_data, dump_data;
  logic [9:0] dump_addr;
  logic dump_valid, dump_busy, dump_done, host_err;
  logic [15:0] model [1024];
  int tests = 0;
  int fails = 0;

  word_mem_streamer dut (
    .clock(clock), .rst(rst), .en(en), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .dump_start(dump_start), .dump_base(dump_base),
    .dump_count(dump_count), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_busy(dump_busy),
    .dump_done(dump_done), .host_err(host_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic start_dump(input logic [9:0] b, input logic [10:0] c);
    dump_base = b;
    dump_count = c;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  initial begin
    int beats, cyc;
    logic seen_done;
    logic [15:0] held;
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
    addr = '0; dump_base = '0; dump_count = '0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_err", host_err, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_dump_addr", dump_addr, 0);

    wr(10'd0, 16'h1234);
    addr = 10'd0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("be_rd", rd_data, 16'h1234);
    chk("be_byte0", dut.u_bank.mem[0], 8'h12);
    chk("be_byte1", dut.u_bank.mem[1], 8'h34);
    addr = 10'd7; wr_data = 16'h5A5A; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; model[7] = 16'h5A5A;
    chk("wr_rd_same", rd_data, 16'h5A5A);

    wr(10'd0, 16'hA1B2); wr(10'd1, 16'hC3D4); wr(10'd2, 16'hE5F6); wr(10'd5, 16'h0505);
    dump_ready = 1'b1;
    start_dump(10'd0, 11'd3);
    chk("d_fetch_busy", dump_busy, 1);
    chk("d_fetch_valid", dump_valid, 0);
    tick();
    chk("d_b0_valid", dump_valid, 1);
    chk("d_b0_addr", dump_addr, 0);
    chk("d_b0_data", dump_data, 16'hA1B2);
    tick();
    chk("d_gap_valid", dump_valid, 0);
    tick();
    chk("d_b1_addr", dump_addr, 1);
    chk("d_b1_data", dump_data, 16'hC3D4);
    tick(); tick();
    chk("d_b2_addr", dump_addr, 2);
    chk("d_b2_data", dump_data, 16'hE5F6);
    chk("d_b2_done", dump_done, 0);
    tick();
    chk("d_done", dump_done, 1);
    chk("d_busy_fall", dump_busy, 0);
    tick();
    chk("d_done_pulse", dump_done, 0);

    wr(10'd1023, 16'hBEEF);
    start_dump(10'd1023, 11'd2);
    tick();
    chk("wrap_a0", dump_addr, 1023);
    chk("wrap_d0", dump_data, 16'hBEEF);
    tick(); tick();
    chk("wrap_a1", dump_addr, 0);
    chk("wrap_d1", dump_data, 16'hA1B2);
    tick();
    chk("wrap_done", dump_done, 1);

    for (int i = 10; i < 14; i++) wr(10'(i), 16'(16'h7700 + i * 16'h0111));
    dump_ready = 1'b0;
    start_dump(10'd10, 11'd4);
    tick();
    held = dump_data;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_valid", dump_valid, 1);
    chk("bp_data_hold", dump_data, held);
    chk("bp_addr_hold", dump_addr, 10);
    en = 1'b0; dump_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("en_addr_hold", dump_addr, 10);
    chk("en_data_hold", dump_data, model[10]);
    en = 1'b1;
    beats = 0; cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 60) begin
      if (dump_valid && dump_ready) begin
        chk("bp_beat_addr", dump_addr, 32'(10 + beats));
        chk("bp_beat_data", dump_data, model[10 + beats]);
        beats++;
      end
      tick();
      cyc++;
      if (dump_done) seen_done = 1'b1;
    end
    chk("bp_beats", beats, 4);
    chk("bp_done_seen", seen_done, 1);

    start_dump(10'd0, 11'd3);
    wr(10'd5, 16'hFFFF);
    model[5] = 16'h0505;
    cyc = 0;
    while (dump_busy && cyc < 40) begin tick(); cyc++; end
    chk("col_drain", dump_busy, 0);
    chk("col_err", host_err, 1);
    addr = 10'd5; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("col_word5", rd_data, 16'h0505);
    tick();
    chk("col_err_sticky", host_err, 1);

    start_dump(10'd0, 11'd3);
    tick();
    chk("rm_in_send", dump_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_valid", dump_valid, 0);
    chk("rm_busy", dump_busy, 0);
    chk("rm_data", dump_data, 0);
    chk("rm_addr", dump_addr, 0);
    chk("rm_rd", rd_data, 0);
    chk("rm_err", host_err, 0);
    chk("rm_done", dump_done, 0);
    start_dump(10'd0, 11'd0);
    chk("z_done", dump_done, 1);
    chk("z_busy", dump_busy, 0);
    chk("z_valid", dump_valid, 0);
    tick();
    chk("z_done_pulse", dump_done, 0);
    start_dump(10'd1, 11'd1);
    tick();
    chk("nd_addr", dump_addr, 1);
    chk("nd_data", dump_data, model[1]);
    tick();
    chk("nd_done", dump_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
